// File: rtl/metaball_shader_if.sv
// Pixel-stage bus for metaball_shader: field/timing inputs from the generator,
// RGB222 colour and delayed syncs towards the VGA pins.
interface metaball_shader_if;
    logic [8:0] field;
    logic       display;
    logic       h_sync;
    logic       v_sync;
    logic       x0;
    logic       y0;
    logic       pause;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       h_sync_o;
    logic       v_sync_o;

    modport master (
        output field, display, h_sync, v_sync, x0, y0, pause,
        input  r, g, b, h_sync_o, v_sync_o
    );

    modport slave (
        input  field, display, h_sync, v_sync, x0, y0, pause,
        output r, g, b, h_sync_o, v_sync_o
    );
endinterface

// File: rtl/metaball_shader.sv
// Two-stage metaball colouring pipeline: banded rotating palette, white blob outline.
// Optional 2x2 ordered dithering is compiled in with `define SHADER_DITHER_EN.
module metaball_shader #(
    parameter int THRESH     = 10,
    parameter int EDGE_W     = 2,
    parameter int BAND_SHIFT = 4,
    parameter int RATE_SHIFT = 2
) (
    input  logic               clk_50mhz,
    input  logic               rst_n,
    metaball_shader_if.slave   bus
);

    localparam int              CNT_W     = (RATE_SHIFT > 0) ? RATE_SHIFT : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((1 << RATE_SHIFT) - 1);
    localparam logic [8:0]      BG_MAX    = 9'(THRESH);
    localparam logic [8:0]      EDGE_MAX  = 9'(THRESH + EDGE_W);
    localparam logic [8:0]      FILL_BASE = 9'(THRESH + EDGE_W + 1);
    localparam logic [1:0]      CLS_BG    = 2'd0;
    localparam logic [1:0]      CLS_EDGE  = 2'd1;
    localparam logic [1:0]      CLS_FILL  = 2'd2;

    function automatic logic [8:0] palette_rgb333(input logic [2:0] idx);
        logic [8:0] rgb;
        case (idx)
            3'd0:    rgb = {3'd7, 3'd0, 3'd0};
            3'd1:    rgb = {3'd7, 3'd4, 3'd0};
            3'd2:    rgb = {3'd6, 3'd7, 3'd0};
            3'd3:    rgb = {3'd0, 3'd7, 3'd2};
            3'd4:    rgb = {3'd0, 3'd6, 3'd7};
            3'd5:    rgb = {3'd2, 3'd2, 3'd7};
            3'd6:    rgb = {3'd5, 3'd0, 3'd7};
            3'd7:    rgb = {3'd7, 3'd0, 3'd5};
            default: rgb = 9'd0;
        endcase
        return rgb;
    endfunction

    // (c + d) >> 1 saturated to 3; with d = 0 this is the plain truncation c >> 1
    function automatic logic [1:0] chan_reduce(input logic [2:0] c, input logic d);
        logic [3:0] sum;
        logic [1:0] out;
        sum = {1'b0, c} + {3'b000, d};
        if (sum[3]) begin
            out = 2'd3;
        end else begin
            out = sum[2:1];
        end
        return out;
    endfunction

    logic [8:0]       diff_s;
    logic [8:0]       band_wide_s;
    logic [1:0]       cls_s;
    logic [1:0]       band_s;
    logic             frame_evt_s;
    logic             dith_s;
    logic [2:0]       idx_s;
    logic [8:0]       pal_s;
    logic [5:0]       colour_s;

    logic             disp1_r;
    logic             hs1_r;
    logic             vs1_r;
    logic [1:0]       cls1_r;
    logic [1:0]       band1_r;
    logic             vs_prev_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic [2:0]       phase_r;
    logic [1:0]       r_r;
    logic [1:0]       g_r;
    logic [1:0]       b_r;
    logic             hs_o_r;
    logic             vs_o_r;

    // Stage-1 field classification and band extraction
    always_comb begin
        diff_s      = bus.field - FILL_BASE;
        band_wide_s = diff_s >> BAND_SHIFT;
        cls_s       = CLS_BG;
        band_s      = 2'd0;
        if (bus.field <= BG_MAX) begin
            cls_s = CLS_BG;
        end else if (bus.field <= EDGE_MAX) begin
            cls_s = CLS_EDGE;
        end else begin
            cls_s = CLS_FILL;
            if (band_wide_s > 9'd3) begin
                band_s = 2'd3;
            end else begin
                band_s = band_wide_s[1:0];
            end
        end
    end

    // Stage-1 pipeline registers; syncs reset inactive so no spurious pulse on release
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            disp1_r <= 1'b0;
            hs1_r   <= 1'b1;
            vs1_r   <= 1'b1;
            cls1_r  <= CLS_BG;
            band1_r <= 2'd0;
        end else begin
            disp1_r <= bus.display;
            hs1_r   <= bus.h_sync;
            vs1_r   <= bus.v_sync;
            cls1_r  <= cls_s;
            band1_r <= band_s;
        end
    end

`ifdef SHADER_DITHER_EN
    logic d1_r;

    // Stage-1 copy of the ordered-dither bit
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            d1_r <= 1'b0;
        end else begin
            d1_r <= bus.x0 ^ bus.y0;
        end
    end

    assign dith_s = d1_r;
`else
    logic unused_dither_s;
    assign unused_dither_s = bus.x0 ^ bus.y0;
    assign dith_s          = 1'b0;
`endif

    assign frame_evt_s = vs_prev_r & ~bus.v_sync;

    // Frame counter and palette phase; a paused frame event is dropped, not deferred
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_r   <= 1'b1;
            frame_cnt_r <= '0;
            phase_r     <= 3'd0;
        end else begin
            vs_prev_r <= bus.v_sync;
            if (frame_evt_s && !bus.pause) begin
                if (frame_cnt_r == CNT_MAX) begin
                    frame_cnt_r <= '0;
                    phase_r     <= phase_r + 3'd1;
                end else begin
                    frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                end
            end else begin
                frame_cnt_r <= frame_cnt_r;
                phase_r     <= phase_r;
            end
        end
    end

    // Stage-2 palette lookup, outline and blanking
    always_comb begin
        idx_s    = {1'b0, band1_r} + phase_r;
        pal_s    = palette_rgb333(idx_s);
        colour_s = 6'd0;
        case (cls1_r)
            CLS_BG:   colour_s = 6'd0;
            CLS_EDGE: colour_s = 6'b11_11_11;
            CLS_FILL: colour_s = {chan_reduce(pal_s[8:6], dith_s),
                                  chan_reduce(pal_s[5:3], dith_s),
                                  chan_reduce(pal_s[2:0], dith_s)};
            default:  colour_s = 6'd0;
        endcase
        if (!disp1_r) begin
            colour_s = 6'd0;
        end else begin
            colour_s = colour_s;
        end
    end

    // Stage-2 output registers
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_r    <= 2'd0;
            g_r    <= 2'd0;
            b_r    <= 2'd0;
            hs_o_r <= 1'b1;
            vs_o_r <= 1'b1;
        end else begin
            r_r    <= colour_s[5:4];
            g_r    <= colour_s[3:2];
            b_r    <= colour_s[1:0];
            hs_o_r <= hs1_r;
            vs_o_r <= vs1_r;
        end
    end

    assign bus.r        = r_r;
    assign bus.g        = g_r;
    assign bus.b        = b_r;
    assign bus.h_sync_o = hs_o_r;
    assign bus.v_sync_o = vs_o_r;

endmodule
